// File: rtl/spr_rom_fetch.sv
// spr_rom_fetch: answers 32-bit sprite ROM word reads with two 16-bit reads on
// the shared SDRAM port. A one-entry tag short-circuits repeats of the last
// fetched word, and a one-deep pending slot absorbs a request issued while busy.
//
// SDRAM handshake: sd_req is a level held high from the start of a read until
// the cycle sd_ack is seen. sd_ack is a one-cycle pulse with sd_data valid in
// that same cycle. sd_addr is stable whenever sd_req is high. sd_req always
// returns to zero for at least one cycle between reads, so every read begins
// with a rising edge. sd_ack outside RD_LO/RD_HI is ignored.
module spr_rom_fetch #(
    parameter int unsigned ADDR_W     = 19,
    parameter logic [23:0] SDRAM_BASE = 24'h100000
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_strobe,
    input  logic              flush,
    output logic [31:0]       rom_dout,
    output logic              rom_valid,
    output logic              busy,
    output logic              late,
    output logic [23:0]       sd_addr,
    output logic              sd_req,
    input  logic              sd_ack,
    input  logic [15:0]       sd_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_GAP   = 3'd2,
        ST_RD_HI = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic                last_valid_q, last_valid_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                pend_v_q, pend_v_d;
    logic                hit_q, hit_d;
    logic [15:0]         lo16_q, lo16_d;
    logic [31:0]         rom_dout_q, rom_dout_d;
    logic                rom_valid_q, rom_valid_d;
    logic                late_q, late_d;
    logic [23:0]         sd_addr_q, sd_addr_d;
    logic                sd_req_q, sd_req_d;

    logic [ADDR_W-1:0]   svc_addr;
    logic                take_pend;

    // Next-state, datapath and pending-slot logic.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_v_d     = pend_v_q;
        hit_d        = hit_q;
        lo16_d       = lo16_q;
        rom_dout_d   = rom_dout_q;
        rom_valid_d  = 1'b0;
        late_d       = late_q;
        sd_addr_d    = sd_addr_q;
        sd_req_d     = 1'b0;

        // The pending request is older than a same-cycle strobe, so it goes first.
        svc_addr  = pend_v_q ? pend_addr_q : req_addr;
        take_pend = (state_q == ST_IDLE) && pend_v_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q || req_strobe) begin
                    cur_addr_d = svc_addr;
                    if (last_valid_q && !flush && (svc_addr == last_addr_q)) begin
                        hit_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        hit_d     = 1'b0;
                        sd_addr_d = SDRAM_BASE + 24'({svc_addr, 2'b00});
                        state_d   = ST_RD_LO;
                    end
                end
            end
            ST_RD_LO: begin
                if (sd_ack) begin
                    lo16_d    = sd_data;
                    // Changes on the same edge sd_req drops, so it never moves while requesting.
                    sd_addr_d = sd_addr_q + 24'd2;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
                if (sd_ack) begin
                    // Both halves land together so rom_dout never shows a half-updated word.
                    rom_dout_d  = {sd_data, lo16_q};
                    rom_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                last_addr_d  = cur_addr_q;
                last_valid_d = 1'b1;
                // A hit keeps the old word; its pulse comes one cycle after DONE.
                if (hit_q) begin
                    rom_valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides the tag write made in DONE.
        if (flush) begin
            last_valid_d = 1'b0;
        end

        if (req_strobe && ((state_q != ST_IDLE) || pend_v_q)) begin
            pend_addr_d = req_addr;
            pend_v_d    = 1'b1;
            if (pend_v_q && !take_pend) begin
                late_d = 1'b1;
            end
        end else if (take_pend) begin
            pend_v_d = 1'b0;
        end

        sd_req_d = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_v_q     <= 1'b0;
            hit_q        <= 1'b0;
            lo16_q       <= 16'h0000;
            rom_dout_q   <= 32'h0000_0000;
            rom_valid_q  <= 1'b0;
            late_q       <= 1'b0;
            sd_addr_q    <= 24'h000000;
            sd_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_v_q     <= pend_v_d;
            hit_q        <= hit_d;
            lo16_q       <= lo16_d;
            rom_dout_q   <= rom_dout_d;
            rom_valid_q  <= rom_valid_d;
            late_q       <= late_d;
            sd_addr_q    <= sd_addr_d;
            sd_req_q     <= sd_req_d;
        end
    end

    assign rom_dout  = rom_dout_q;
    assign rom_valid = rom_valid_q;
    assign late      = late_q;
    assign sd_addr   = sd_addr_q;
    assign sd_req    = sd_req_q;
    assign busy      = (state_q != ST_IDLE) || pend_v_q;

endmodule
